// File: rtl/reservation_station_aged_if.sv
// Reservation station type package and dispatch/wakeup/issue interface.
// The package carries the instruction payload shared by the RS and its
// neighbours. The interface bundles every handshake/bus signal of the RS.
// The optional flush port (RS_FLUSH_EN) is a plain module port, not a member.

package rs_aged_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    // Instruction as written by dispatch: own ROB tag plus two source operands,
    // each either ready (value valid) or waiting on a producer tag.
    typedef struct packed {
        logic [7:0]             op;
        logic [ROB_TAG_LEN-1:0] insn_tag;
        logic [ROB_TAG_LEN-1:0] tag_src1;
        logic                   ready_src1;
        logic [XLEN-1:0]        value_src1;
        logic [ROB_TAG_LEN-1:0] tag_src2;
        logic                   ready_src2;
        logic [XLEN-1:0]        value_src2;
    } inst_rs_t;

    // Issue payload carries the same fields; both sources are ready by then.
    typedef inst_rs_t rs_entry_t;
endpackage

interface reservation_station_aged_if
    import rs_aged_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_WAKEUP  = 4
);
    // dispatch
    logic                                   load;
    inst_rs_t                               insn_load;
    // common data bus wakeup
    logic [NUM_WAKEUP-1:0]                  wakeup;
    logic [NUM_WAKEUP-1:0][ROB_TAG_LEN-1:0] wakeup_tag;
    logic [NUM_WAKEUP-1:0][XLEN-1:0]        wakeup_value;
    // squash by tag
    logic                                   clear;
    logic [ROB_TAG_LEN-1:0]                 clear_tag;
    // issue handshake
    logic                                   issue_ready;
    logic                                   issue_valid;
    rs_entry_t                              insn_for_ex;
    // occupancy
    logic                                   is_full;
    logic                                   is_empty;
    logic [$clog2(NUM_ENTRIES+1)-1:0]       count;

    // Producer side (dispatch, CDB, ROB, FU) drives requests and watches status.
    modport master (
        output load, insn_load, wakeup, wakeup_tag, wakeup_value,
               clear, clear_tag, issue_ready,
        input  issue_valid, insn_for_ex, is_full, is_empty, count
    );

    // The reservation station itself.
    modport slave (
        input  load, insn_load, wakeup, wakeup_tag, wakeup_value,
               clear, clear_tag, issue_ready,
        output issue_valid, insn_for_ex, is_full, is_empty, count
    );
endinterface

// File: rtl/reservation_station_aged.sv
// Age-ordered reservation station.
// Non-shifting slots, an NUM_ENTRIES x NUM_ENTRIES age matrix for oldest-ready
// select, CDB wakeup, tag squash and a registered issue output stage.
// Optional feature macro: RS_FLUSH_EN adds a 'flush' port that clears
// every slot and the output stage at the next edge.

module reservation_station_aged
    import rs_aged_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_WAKEUP  = 4
) (
    input  logic                        clk,
    input  logic                        reset,   // active low, asynchronous
`ifdef RS_FLUSH_EN
    input  logic                        flush,
`endif
    reservation_station_aged_if.slave   rs
);

    localparam int CW = $clog2(NUM_ENTRIES + 1);

    // ---------------------------------------------------------------------
    // State
    // age_q[i][j] = 1 means slot i is older than slot j. Only meaningful
    // between valid slots; the diagonal is always 0.
    // ---------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0]                  valid_q, valid_d;
    inst_rs_t                                entry_q [NUM_ENTRIES];
    inst_rs_t                                entry_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;
    logic                                    out_valid_q, out_valid_d;
    rs_entry_t                               out_q, out_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0] clr_hit;    // slot squashed this cycle
    logic [NUM_ENTRIES-1:0] cand;       // valid, both ready, not squashed
    logic [NUM_ENTRIES-1:0] sel_oh;     // oldest candidate
    logic [NUM_ENTRIES-1:0] load_oh;    // lowest free slot
    inst_rs_t               sel_entry;
    inst_rs_t               load_woken;
    logic                   refill;
    logic                   load_ok;
    logic                   full;
    logic [CW-1:0]          cnt;

    // Capture any matching broadcast on a waiting source. The loop runs from
    // the highest channel down so the lowest matching channel is written last.
    function automatic inst_rs_t apply_wakeup(
        input inst_rs_t                               e,
        input logic [NUM_WAKEUP-1:0]                  wk,
        input logic [NUM_WAKEUP-1:0][ROB_TAG_LEN-1:0] wk_tag,
        input logic [NUM_WAKEUP-1:0][XLEN-1:0]        wk_val
    );
        inst_rs_t r;
        r = e;
        for (int c = NUM_WAKEUP - 1; c >= 0; c--) begin
            if (wk[c] && !e.ready_src1 && wk_tag[c] == e.tag_src1) begin
                r.ready_src1 = 1'b1;
                r.value_src1 = wk_val[c];
            end
            if (wk[c] && !e.ready_src2 && wk_tag[c] == e.tag_src2) begin
                r.ready_src2 = 1'b1;
                r.value_src2 = wk_val[c];
            end
        end
        return r;
    endfunction

    // Occupancy counter and full flag from registered valid bits only.
    always_comb begin
        cnt  = '0;
        full = 1'b1;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cnt  = cnt + CW'(valid_q[i]);
            full = full & valid_q[i];
        end
    end

    // Squash hits and oldest-ready selection. A squashed slot is removed
    // from the candidate set so clear always wins over select.
    always_comb begin
        clr_hit   = '0;
        cand      = '0;
        sel_oh    = '0;
        sel_entry = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            clr_hit[i] = rs.clear && valid_q[i] && (entry_q[i].insn_tag == rs.clear_tag);
            cand[i]    = valid_q[i] && !clr_hit[i] &&
                         entry_q[i].ready_src1 && entry_q[i].ready_src2;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (cand[j] && age_q[j][i])
                    sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i])
                sel_entry = entry_q[i];
        end
    end

    // Lowest-index free slot for dispatch; a load squashed in the same
    // cycle or arriving while full is dropped.
    always_comb begin
        load_oh = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                load_oh    = '0;
                load_oh[i] = 1'b1;
            end
        end
        load_ok = rs.load && !full &&
                  !(rs.clear && rs.insn_load.insn_tag == rs.clear_tag);
        load_woken = apply_wakeup(rs.insn_load, rs.wakeup, rs.wakeup_tag, rs.wakeup_value);
    end

    // Next-state: wakeup, squash, issue refill, dispatch write, age update.
    always_comb begin
        valid_d     = valid_q & ~clr_hit;
        age_d       = age_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        refill      = !out_valid_q || rs.issue_ready;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i] = valid_q[i]
                       ? apply_wakeup(entry_q[i], rs.wakeup, rs.wakeup_tag, rs.wakeup_value)
                       : entry_q[i];
        end

        // Output stage: refill on an empty or accepted stage, else hold
        // bit-stable unless the held instruction is squashed.
        if (refill) begin
            out_valid_d = |sel_oh;
            if (|sel_oh)
                out_d = sel_entry;
            valid_d = valid_d & ~sel_oh;
        end else if (rs.clear && out_q.insn_tag == rs.clear_tag) begin
            out_valid_d = 1'b0;
        end

        // New slot becomes younger than every other slot.
        if (load_ok) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (load_oh[i]) begin
                    valid_d[i] = 1'b1;
                    entry_d[i] = load_woken;
                    for (int j = 0; j < NUM_ENTRIES; j++) begin
                        age_d[i][j] = 1'b0;
                        age_d[j][i] = (j != i);
                    end
                end
            end
        end

`ifdef RS_FLUSH_EN
        if (flush) begin
            valid_d     = '0;
            age_d       = '0;
            out_valid_d = 1'b0;
        end
`endif
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            age_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                entry_q[i] <= '0;
        end else begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int i = 0; i < NUM_ENTRIES; i++)
                entry_q[i] <= entry_d[i];
        end
    end

    assign rs.issue_valid = out_valid_q;
    assign rs.insn_for_ex = out_q;
    assign rs.count       = cnt;
    assign rs.is_full     = full;
    assign rs.is_empty    = !(|valid_q) && !out_valid_q;

endmodule
